mem_load_queue: RTL
===================

# mem_load_queue

Parametrised load-return unit for the MEM stage: tracks up to DEPTH outstanding data-SRAM load requests, records per-request alignment info, captures `data_sram_rdata` on each `data_sram_data_ok`, and presents aligned results (LW/LH/LHU/LB/LBU/LWL/LWR) to WB in request order with a valid/ready handshake. It replaces the single-entry rdata buffer so the pipeline can issue a new load before the previous one returns. On an exception flush it cancels queued loads and silently discards their late SRAM responses.

## Interface
- `DEPTH`, 2, maximum outstanding loads (queue entries + pending discards); power of two, ≥1.
- `DEST_W`, 5, width of destination register tag.
- `clk`  in  1  clock.
- `reset`  in  1  reset; one clock, synchronous and active-high.
- `req_valid`  in  1  a load address handshake completed this cycle (SRAM will return exactly one `data_sram_data_ok`).
- `req_mode`  in  3  0=W, 1=H, 2=B, 3=LWL, 4=LWR; others treated as W.
- `req_sext`  in  1  sign-extend for H/B.
- `req_off`  in  2  address bits [1:0].
- `req_dest`  in  DEST_W  destination register.
- `req_rt`  in  32  rt value merged by LWL/LWR.
- `req_ready`  out  1  a request can be accepted this cycle.
- `data_sram_data_ok`  in  1  response strobe, strictly in request order.
- `data_sram_rdata`  in  32  response data, valid only with `data_sram_data_ok`.
- `flush`  in  1  exception/ERET flush from WB.
- `resp_valid`  out  1  head entry has data.
- `resp_ready`  in  1  WB accepts.
- `resp_dest`  out  DEST_W  head destination.
- `resp_data`  out  32  aligned head result.
- `outstanding`  out  $clog2(DEPTH+1)  entries + discard count.
- `proto_err`  out  1  sticky protocol-error flag.

## Operation
- State: circular queue of DEPTH entries {mode, sext, off, dest, rt, raw, got}; head/tail pointers with wrap; entry count; `pend` = entries with got=0; `discard` counter.
- Push: `req_valid && req_ready` writes tail, got=0.
- Return: `data_sram_data_ok` with `discard`>0 → discard-1, data dropped. Otherwise writes raw to oldest entry with got=0 and sets got.
- Pop: `resp_valid && resp_ready` advances head.
- `req_ready = (count + discard) < DEPTH`; depends on registered state only, never on `resp_ready` or `data_ok`.
- Flush: all entries invalidated. `discard_next = discard + pend + req_valid - (data_ok ? 1 : 0)`. A `req_valid` in the flush cycle is never enqueued, but its response is counted for discard. Pop in the flush cycle is ignored.
- Alignment on output, from raw r and rt:
  - W: r.
  - H: half `r[16*off[1] +: 16]`, extended by sext.
  - B: byte `r[8*off +: 8]`, extended by sext.
  - LWL: off0 {r[7:0],rt[23:0]}, off1 {r[15:0],rt[15:0]}, off2 {r[23:0],rt[7:0]}, off3 r.
  - LWR: off3 {rt[31:8],r[31:24]}, off2 {rt[31:16],r[31:16]}, off1 {rt[31:24],r[31:8]}, off0 r.
- Errors, each sets `proto_err` (cleared only by reset); state is unchanged by the offending event:
  - `data_ok` with pend=0 and discard=0 is ignored.
  - `req_valid` with `req_ready`=0 is dropped.

## Timing
- Reset: pointers, count, discard, all got bits cleared; `resp_valid`=0, `req_ready`=1, `outstanding`=0, `proto_err`=0, `resp_data`/`resp_dest`=0.
- Throughput: one push, one return and one pop per cycle, simultaneously.
- Full condition: push is blocked. A pop in the same cycle frees the slot only from the next cycle.
- Latency from `data_ok` in cycle N for the head entry to `resp_valid`: see Configuration. Non-head returns are visible once they become head.
- `resp_valid`/`resp_data` are held stable until accepted or flushed.
- Reset asserted mid-operation discards everything, including the discard count; the environment must also reset the SRAM.

## Configuration
- `MEM_LOAD_BYPASS_EN` defined: when `data_ok` returns data for the head entry and discard=0, `resp_valid`=1 in cycle N with `resp_data` aligned combinationally from `data_sram_rdata`. The data is also captured, so a stall holds it.
- Not defined: `resp_valid` earliest in N+1 from captured raw. Output is fully registered-state driven and there is no rdata→resp path.

## Test plan
- LB, off=3, sext=1, rdata=0x80_12_34_56 → resp_data 0xFFFFFF80. Same request with sext=0 → 0x00000080.
- LWL, off=1, rt=0xAABBCCDD, rdata=0x11223344 → 0x3344CCDD. LWR, off=1, same inputs → 0xAA112233.
- DEPTH=2: two pushes → `req_ready`=0 and `outstanding`=2. Then `data_ok` twice with `resp_ready`=0 → both retained and popped in order; `req_ready` rises the cycle after the first pop.
- Two pending loads, flush together with a third `req_valid` → `discard`=3. The next three `data_ok` are dropped with `resp_valid`=0. A fourth load is then returned normally.
- Bypass: with the macro defined, `data_ok` for the head entry → `resp_valid` in the same cycle. Without the macro → `resp_valid` in the next cycle.
- `data_ok` on an empty queue → `proto_err`=1 and `outstanding` unchanged. A subsequent reset clears `proto_err`.

Source files
------------

// File: rtl/mem_load_queue.sv
// MEM-stage load-return queue: tracks outstanding SRAM loads, aligns returned data, delivers in order.
// Optional MEM_LOAD_BYPASS_EN: head-entry return is forwarded to resp_* in the same cycle.
module mem_load_queue #(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 5,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_mode,
  input  logic              req_sext,
  input  logic [1:0]        req_off,
  input  logic [DEST_W-1:0] req_dest,
  input  logic [31:0]       req_rt,
  output logic              req_ready,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DEST_W-1:0] resp_dest,
  output logic [31:0]       resp_data,
  output logic [CW-1:0]     outstanding,
  output logic              proto_err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // A flush with a same-cycle request can leave DEPTH+1 responses to drop.
  localparam int DW = $clog2(DEPTH + 2);

  logic [2:0]        mode_q [DEPTH];
  logic              sext_q [DEPTH];
  logic [1:0]        off_q  [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [31:0]       rt_q   [DEPTH];
  logic [31:0]       raw_q  [DEPTH];
  logic [DEPTH-1:0]  got_q;
  logic [PW-1:0]     head_q, tail_q, rptr_q;
  logic [CW-1:0]     count_q, count_d, pend_q, pend_d;
  logic [DW-1:0]     discard_q, discard_d;
  logic              proto_err_q;

  logic [DW:0]   occ;
  logic          push, pop, ret_live, drop, bad_req, bad_ret, head_got;
  logic [31:0]   raw_sel;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] align(input logic [2:0] m, input logic s,
                                        input logic [1:0] o, input logic [31:0] r,
                                        input logic [31:0] rt);
    logic [15:0] h;
    logic [7:0]  b;
    h = o[1] ? r[31:16] : r[15:0];
    b = r[8*o +: 8];
    case (m)
      3'd1: return {{16{s & h[15]}}, h};
      3'd2: return {{24{s & b[7]}}, b};
      3'd3: case (o)
              2'd0: return {r[7:0],  rt[23:0]};
              2'd1: return {r[15:0], rt[15:0]};
              2'd2: return {r[23:0], rt[7:0]};
              default: return r;
            endcase
      3'd4: case (o)
              2'd3: return {rt[31:8],  r[31:24]};
              2'd2: return {rt[31:16], r[31:16]};
              2'd1: return {rt[31:24], r[31:8]};
              default: return r;
            endcase
      default: return r;
    endcase
  endfunction

  assign occ       = (DW+1)'(count_q) + (DW+1)'(discard_q);
  assign req_ready = occ < (DW+1)'(DEPTH);
  assign outstanding = (occ > (DW+1)'({CW{1'b1}})) ? {CW{1'b1}} : occ[CW-1:0];
  assign proto_err = proto_err_q;

  assign head_got = got_q[head_q] && (count_q != '0);
  assign drop     = data_sram_data_ok && (discard_q != '0);
  assign ret_live = data_sram_data_ok && (discard_q == '0) && (pend_q != '0);
  assign bad_ret  = data_sram_data_ok && (discard_q == '0) && (pend_q == '0);
  assign bad_req  = req_valid && !req_ready && !flush;
  assign push     = req_valid && req_ready && !flush;
  assign pop      = resp_valid && resp_ready && !flush;

`ifdef MEM_LOAD_BYPASS_EN
  logic byp;
  // The oldest un-returned entry is the head exactly when rptr meets head.
  assign byp        = ret_live && (rptr_q == head_q) && !head_got;
  assign resp_valid = head_got || byp;
  assign raw_sel    = byp ? data_sram_rdata : raw_q[head_q];
`else
  assign resp_valid = head_got;
  assign raw_sel    = raw_q[head_q];
`endif

  assign resp_data = resp_valid ? align(mode_q[head_q], sext_q[head_q], off_q[head_q],
                                        raw_sel, rt_q[head_q]) : '0;
  assign resp_dest = resp_valid ? dest_q[head_q] : '0;

  always_comb begin
    count_d   = count_q + CW'(push) - CW'(pop);
    pend_d    = pend_q + CW'(push) - CW'(ret_live);
    discard_d = discard_q - DW'(drop);
    if (flush) begin
      count_d   = '0;
      pend_d    = '0;
      discard_d = DW'((DW+1)'(discard_q) + (DW+1)'(pend_q) + (DW+1)'(req_valid)
                      - (DW+1)'(drop || ret_live));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      discard_q   <= '0;
      got_q       <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mode_q[i] <= '0;
        sext_q[i] <= 1'b0;
        off_q[i]  <= '0;
        dest_q[i] <= '0;
        rt_q[i]   <= '0;
        raw_q[i]  <= '0;
      end
    end else begin
      count_q   <= count_d;
      pend_q    <= pend_d;
      discard_q <= discard_d;
      if (bad_req || bad_ret) proto_err_q <= 1'b1;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        rptr_q <= '0;
        got_q  <= '0;
      end else begin
        if (push) begin
          mode_q[tail_q] <= req_mode;
          sext_q[tail_q] <= req_sext;
          off_q[tail_q]  <= req_off;
          dest_q[tail_q] <= req_dest;
          rt_q[tail_q]   <= req_rt;
          got_q[tail_q]  <= 1'b0;
          tail_q         <= inc(tail_q);
        end
        if (ret_live) begin
          raw_q[rptr_q] <= data_sram_rdata;
          got_q[rptr_q] <= 1'b1;
          rptr_q        <= inc(rptr_q);
        end
        if (pop) head_q <= inc(head_q);
      end
    end
  end
endmodule
